// File: rtl/ld_nn_a_store_sequencer.sv
// LD (nn),A execution sequencer: fetches the 16-bit operand nn,
// then stores the latched accumulator to memory address nn.
module ld_nn_a_store_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [15:0] PC_in,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic [3:0]  XPT,
    output logic [15:0] PC_out,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        FETCH_L = 4'd3,
        FETCH_H = 4'd4,
        WRITE   = 4'd5,
        DONE    = 4'd6
    } state_t;

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    state_t      state, state_n;
    logic [7:0]  wait_cnt, wait_n;
    logic [15:0] nn, nn_n;
    logic [15:0] pc, pc_n;
    logic [7:0]  a_reg, a_n;
    logic        req_n, we_n;
    logic [15:0] addr_n;
    logic [7:0]  wdata_n;
    logic [15:0] pcout_n;
    logic        done_n, fault_n;
    logic        ack_ok;
    logic        expired;

    // An ack only counts while a request is actually outstanding.
    assign ack_ok  = mem_req & mem_ack;
    assign expired = !ack_ok && (wait_cnt == TMO);

    assign XPT  = state;
    assign busy = (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            nn        <= 16'd0;
            pc        <= 16'd0;
            a_reg     <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 8'd0;
            PC_out    <= 16'd0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            nn        <= nn_n;
            pc        <= pc_n;
            a_reg     <= a_n;
            mem_req   <= req_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            PC_out    <= pcout_n;
            done      <= done_n;
            fault     <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        nn_n    = nn;
        pc_n    = pc;
        a_n     = a_reg;
        req_n   = mem_req;
        we_n    = mem_we;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        pcout_n = PC_out;
        done_n  = 1'b0;
        fault_n = 1'b0;

        unique case (state)
            IDLE: begin
                req_n = 1'b0;
                we_n  = 1'b0;
                if (start) begin
                    state_n = FETCH_L;
                    a_n     = A;
                    pc_n    = PC_in;
                    wait_n  = 8'd0;
                    req_n   = 1'b1;
                    addr_n  = PC_in;
                end
            end
            FETCH_L: begin
                if (ack_ok) begin
                    state_n = FETCH_H;
                    nn_n    = {nn[15:8], mem_rdata};
                    wait_n  = 8'd0;
                    addr_n  = pc + 16'd1;
                end else if (expired) begin
                    state_n = IDLE;
                    wait_n  = 8'd0;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    fault_n = 1'b1;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            FETCH_H: begin
                if (ack_ok) begin
                    state_n = WRITE;
                    nn_n    = {mem_rdata, nn[7:0]};
                    wait_n  = 8'd0;
                    we_n    = 1'b1;
                    addr_n  = {mem_rdata, nn[7:0]};
                    wdata_n = a_reg;
                end else if (expired) begin
                    state_n = IDLE;
                    wait_n  = 8'd0;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    fault_n = 1'b1;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            WRITE: begin
                if (ack_ok) begin
                    state_n = DONE;
                    wait_n  = 8'd0;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    done_n  = 1'b1;
                    pcout_n = pc + 16'd2;
                end else if (expired) begin
                    state_n = IDLE;
                    wait_n  = 8'd0;
                    req_n   = 1'b0;
                    we_n    = 1'b0;
                    fault_n = 1'b1;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                wait_n  = 8'd0;
                req_n   = 1'b0;
                we_n    = 1'b0;
            end
            default: begin
                state_n = IDLE;
                wait_n  = 8'd0;
                req_n   = 1'b0;
                we_n    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ld_nn_a_store_sequencer.sv
// Bench for ld_nn_a_store_sequencer: directed and random store
// sequences checked cycle by cycle against a transfer-level model.
module tb_ld_nn_a_store_sequencer;

    localparam int T = 3;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic [7:0]  A;
    logic [15:0] PC_in;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [3:0]  XPT;
    logic [15:0] PC_out;
    logic        busy;
    logic        done;
    logic        fault;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  xpt;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        done;
        logic        fault;
    } cyc_t;

    ld_nn_a_store_sequencer #(.ACK_TIMEOUT(T)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .A(A),
        .PC_in(PC_in), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .XPT(XPT), .PC_out(PC_out),
        .busy(busy), .done(done), .fault(fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic cyc_t mk(input logic [3:0] x, input logic rq,
                                input logic w, input logic [15:0] ad,
                                input logic [7:0] wd, input logic d,
                                input logic f);
        cyc_t c;
        c.xpt = x; c.req = rq; c.we = w; c.addr = ad;
        c.wdata = wd; c.done = d; c.fault = f;
        return c;
    endfunction

    // Model: three transfers, each lasting waits+1 cycles when it
    // completes within T waits, otherwise T+1 cycles then an abort.
    task automatic run_seq(input logic [15:0] pc, input logic [7:0] a,
                           input int w0, input int w1, input int w2,
                           input bit mid);
        int w[3];
        logic [15:0] ad[3];
        cyc_t e[$];
        cyc_t r;
        bit ok;
        int idx;
        int wc;
        logic [15:0] wa[$];
        logic [7:0] wd[$];
        w[0] = w0; w[1] = w1; w[2] = w2;
        ad[0] = pc;
        ad[1] = pc + 16'd1;
        ad[2] = {mem[ad[1]], mem[pc]};
        ok = 1'b1;
        for (int t = 0; t < 3; t++) begin
            int n;
            if (ok) begin
                n = (w[t] <= T) ? w[t] + 1 : T + 1;
                for (int i = 0; i < n; i++)
                    e.push_back(mk(4'(3 + t), 1'b1, (t == 2), ad[t], a, 1'b0, 1'b0));
                if (w[t] > T) begin
                    ok = 1'b0;
                    e.push_back(mk(4'd0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b1));
                end
            end
        end
        if (ok) e.push_back(mk(4'd6, 1'b0, 1'b0, 16'd0, 8'd0, 1'b1, 1'b0));
        e.push_back(mk(4'd0, 1'b0, 1'b0, 16'd0, 8'd0, 1'b0, 1'b0));

        @(negedge CLK);
        A = a; PC_in = pc; start = 1'b1; mem_ack = 1'b0;
        idx = 0; wc = 0;
        for (int k = 1; k <= e.size(); k++) begin
            @(negedge CLK);
            r = e[k-1];
            chk($sformatf("xpt@%0d", k), 32'(XPT), 32'(r.xpt));
            chk($sformatf("req@%0d", k), 32'(mem_req), 32'(r.req));
            chk($sformatf("busy@%0d", k), 32'(busy), 32'(r.xpt != 4'd0));
            chk($sformatf("done@%0d", k), 32'(done), 32'(r.done));
            chk($sformatf("fault@%0d", k), 32'(fault), 32'(r.fault));
            if (r.req) begin
                chk($sformatf("we@%0d", k), 32'(mem_we), 32'(r.we));
                chk($sformatf("addr@%0d", k), 32'(mem_addr), 32'(r.addr));
                if (r.we)
                    chk($sformatf("wdata@%0d", k), 32'(mem_wdata), 32'(r.wdata));
            end
            if (r.done)
                chk("pc_out", 32'(PC_out), 32'(16'(pc + 16'd2)));
            start = mid && (k == w0 + 2 || (ok && k == e.size() - 1));
            if (start) A = 8'hFF;
            mem_ack = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req && idx < 3) begin
                if (wc >= w[idx]) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        wa.push_back(mem_addr);
                        wd.push_back(mem_wdata);
                    end else begin
                        mem_rdata = mem[mem_addr];
                    end
                    idx++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end
        end
        start = 1'b0;
        mem_ack = 1'b0;
        chk("write_count", 32'(wa.size()), ok ? 32'd1 : 32'd0);
        if (wa.size() > 0) begin
            chk("write_addr", 32'(wa[0]), 32'(ad[2]));
            chk("write_data", 32'(wd[0]), 32'(a));
        end
    endtask

    initial begin
        logic [15:0] pc;
        int w0;
        RESET = 1'b1; start = 1'b0; A = 8'h00; PC_in = 16'h0000;
        mem_rdata = 8'h00; mem_ack = 1'b0;
        #3;
        chk("rst_xpt", 32'(XPT), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_pc_out", 32'(PC_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
        run_seq(16'h1000, 8'h5A, 0, 0, 0, 1'b0);
        run_seq(16'h1000, 8'h5A, 2, 2, 2, 1'b0);

        mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
        run_seq(16'hFFFF, 8'hC3, 0, 0, 0, 1'b0);

        mem[16'h2000] = 8'hEF; mem[16'h2001] = 8'hBE;
        run_seq(16'h2000, 8'h77, 0, 1, 255, 1'b0);
        run_seq(16'h2000, 8'h77, 1, 0, T, 1'b0);

        mem[16'h1000] = 8'h34; mem[16'h1001] = 8'h12;
        run_seq(16'h1000, 8'h5A, 0, 1, 0, 1'b1);

        mem[16'h3000] = 8'h78; mem[16'h3001] = 8'h56;
        @(negedge CLK);
        A = 8'h99; PC_in = 16'h3000; start = 1'b1;
        @(negedge CLK);
        start = 1'b0; mem_ack = 1'b1; mem_rdata = mem[16'h3000];
        @(negedge CLK);
        mem_rdata = mem[16'h3001];
        @(negedge CLK);
        mem_ack = 1'b0;
        chk("pre_rst_xpt", 32'(XPT), 32'd5);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        chk("pre_rst_addr", 32'(mem_addr), 32'h5678);
        chk("pre_rst_wdata", 32'(mem_wdata), 32'h99);
        #2 RESET = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_xpt", 32'(XPT), 32'd0);
        chk("arst_pc_out", 32'(PC_out), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        run_seq(16'h3000, 8'h11, 0, 0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            pc = 16'($urandom);
            mem[pc] = 8'($urandom);
            mem[16'(pc + 16'd1)] = 8'($urandom);
            w0 = $urandom_range(0, 4);
            run_seq(pc, 8'($urandom), w0, $urandom_range(0, 4),
                    $urandom_range(0, 4),
                    (w0 <= T) && ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ld_nn_a_store_sequencer.md
Name: ld_nn_a_store_sequencer

Overview:
- Execution sequencer for LD (nn),A: the write-direction counterpart of the LD A,(nn) step decoder.
- After the opcode is recognised, it fetches the low and high bytes of the 16-bit operand nn from the instruction stream, then writes accumulator A to memory address nn.
- Drives the XPT step number, a req/ack memory handshake, and the PC update.
- Sits between the instruction decoder (start pulse) and the memory bus arbiter.

Parameters:
- ACK_TIMEOUT, 15, maximum number of wait cycles per bus transfer before the sequence aborts; legal range 1..255.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse from the decoder; LD (nn),A opcode recognised.
- A  input  8  accumulator value; sampled on the accepted start.
- PC_in  input  16  address of the first operand byte; sampled on the accepted start.
- mem_rdata  input  8  read data; valid in the cycle mem_ack is high on a read.
- mem_ack  input  1  transfer-complete strobe from the arbiter.
- mem_req  output  1  bus transfer request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  output  16  transfer address.
- mem_wdata  output  8  write data.
- XPT  output  4  current step number.
- PC_out  output  16  updated PC, equal to PC_in+2 mod 2^16; valid when done is high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- fault  output  1  one-cycle pulse on handshake timeout.

Behaviour:
- Reset values, applied asynchronously: state IDLE, XPT=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, PC_out=0, busy=0, done=0, fault=0, wait counter=0, nn register=0.
- States and XPT encoding: IDLE (XPT=0), FETCH_L (3), FETCH_H (4), WRITE (5), DONE (6).
- IDLE:
  - start=1 at an edge latches A, PC_in into pc, and moves to FETCH_L.
  - start is ignored whenever busy=1; no queuing.
- FETCH_L:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On an edge with mem_ack=1: nn[7:0] <= mem_rdata; go to FETCH_H.
- FETCH_H:
  - mem_req=1, mem_we=0, mem_addr=pc+1 (16-bit wrap: 0xFFFF+1 = 0x0000).
  - On ack: nn[15:8] <= mem_rdata; go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=nn, mem_wdata=latched A.
  - On ack: go to DONE.
- DONE:
  - mem_req=0, done=1, PC_out=pc+2 mod 2^16.
  - Next edge returns to IDLE with XPT=0.
  - A start arriving in DONE is ignored.
- Handshake rules:
  - mem_req and all address/data outputs are registered and stable until the acked edge.
  - mem_ack is sampled only while mem_req=1; ack with req low is ignored.
  - Zero-wait ack (ack in the first req cycle) completes that transfer.
  - Between back-to-back transfers mem_req stays high; address and we change on the acked edge.
- Latency: with zero-wait acks, start edge -> done high is 4 cycles (FETCH_L, FETCH_H, WRITE, DONE). Each wait cycle adds 1.
- Timeout:
  - The wait counter clears on each state entry and increments each req cycle without ack.
  - If ACK_TIMEOUT wait cycles elapse without ack, the next edge goes to IDLE, drops mem_req and pulses fault=1 for one cycle.
  - No memory write has occurred if the timeout hits before the WRITE ack.
- Reset mid-operation: mem_req falls immediately (asynchronous). A write not yet acked is abandoned and PC_out is not updated.
- busy=1 in FETCH_L, FETCH_H, WRITE and DONE.

Test Plan:
- Basic store: PC_in=0x1000, A=0x5A, mem[0x1000]=0x34, mem[0x1001]=0x12, zero-wait acks -> reads at 0x1000 and 0x1001, write 0x5A to 0x1234, XPT sequence 3,4,5,6,0, done 4 cycles after start, PC_out=0x1002.
- Wait states: same stimulus with 2 wait cycles on each transfer -> identical bus transactions, done 10 cycles after start, mem_req continuously high from FETCH_L through WRITE.
- PC wrap: PC_in=0xFFFF, mem[0xFFFF]=0x00, mem[0x0000]=0x80, A=0xC3 -> second read at 0x0000, write 0xC3 to 0x8000, PC_out=0x0001.
- Timeout: ACK_TIMEOUT=3, never ack the WRITE -> after 3 wait cycles fault pulses once, mem_req=0, XPT=0, done never asserts, no write completes.
- Start while busy and A change: second start during FETCH_H with A changed to 0xFF -> ignored, write data stays the originally latched A.
- Async reset during WRITE with mem_req high -> mem_req, busy and XPT read 0 before the next CLK edge; a fresh start afterwards runs a normal sequence.
